// File: rtl/gate_io_pkg.sv
// Shared constants for the gate controller input conditioning path.
//   DEBOUNCE_27M_20MS : debounce window of 20 ms at 27 MHz, in clock cycles
//   HOLD_27M_1S       : long-press threshold of 1 s at 27 MHz, in clock cycles
//   SW_SENSOR/SW_MOTOR: bit positions of the two slide switches in SW_RAW/SW_CLEAN
//   KEY_IDLE/SW_IDLE  : released/idle levels, also used as reset values
package gate_io_pkg;
  localparam int DEBOUNCE_27M_20MS = 540000;
  localparam int HOLD_27M_1S       = 27000000;

  localparam int SW_SENSOR = 0;
  localparam int SW_MOTOR  = 1;

  localparam logic KEY_IDLE = 1'b1;
  localparam logic SW_IDLE  = 1'b0;
endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: 2-FF synchroniser, stability counter, stable register.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing samples needed before level flips (>= 2)
//   IDLE            : reset value of the synchroniser flops and the stable level
// Ports:
//   clk    : sampling clock (rising edge)
//   rst    : asynchronous active-high reset
//   raw    : asynchronous, possibly bouncing input
//   level  : debounced level (registered)
//   change : high in the cycle whose rising edge will flip level; lets the
//            parent register edge pulses that line up with the level change
module debounce_channel #(
  parameter int   DEBOUNCE_CYCLES = 8,
  parameter logic IDLE            = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The counter tracks how many consecutive edges sync2 has disagreed with
  // level; the flip happens on the edge where that run reaches DEBOUNCE_CYCLES.
  assign change = (sync2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      level <= IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (change) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gate_input_conditioner.sv
// Input conditioning for the gate controller: synchronises and debounces the
// active-low push-button and the two slide switches, and produces a one-cycle
// press pulse on each debounced key press.
//
// Optional feature (macro GATE_INPUT_HOLD_DETECT_EN): long-press detection.
// When defined, KEY_HOLD is high once the debounced key has been held for
// HOLD_CYCLES cycles; when undefined, KEY_HOLD is tied to 0.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles before any output level changes (>= 2)
//   HOLD_CYCLES     : debounced-pressed cycles before KEY_HOLD asserts
// Ports:
//   CLOCK_27    : board clock, all state on rising edge
//   RESET       : asynchronous active-high reset
//   KEY_RAW_N   : raw push-button, active-low
//   SW_RAW      : raw switches, [0] sensor, [1] motor
//   KEY_CLEAN_N : debounced key level, active-low
//   KEY_PRESS   : one-cycle pulse on each debounced press
//   SW_CLEAN    : debounced switch levels
//   KEY_HOLD    : long-press level
module gate_input_conditioner
  import gate_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_27M_20MS,
  parameter int HOLD_CYCLES     = HOLD_27M_1S
) (
  input  logic       CLOCK_27,
  input  logic       RESET,
  input  logic       KEY_RAW_N,
  input  logic [1:0] SW_RAW,
  output logic       KEY_CLEAN_N,
  output logic       KEY_PRESS,
  output logic [1:0] SW_CLEAN,
  output logic       KEY_HOLD
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end

  logic       key_level;
  logic       key_change;
  logic [1:0] sw_level;
  logic [1:0] sw_change_unused;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE           (KEY_IDLE)
  ) u_key (
    .clk   (CLOCK_27),
    .rst   (RESET),
    .raw   (KEY_RAW_N),
    .level (key_level),
    .change(key_change)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE           (SW_IDLE)
  ) u_sw_sensor (
    .clk   (CLOCK_27),
    .rst   (RESET),
    .raw   (SW_RAW[SW_SENSOR]),
    .level (sw_level[SW_SENSOR]),
    .change(sw_change_unused[SW_SENSOR])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE           (SW_IDLE)
  ) u_sw_motor (
    .clk   (CLOCK_27),
    .rst   (RESET),
    .raw   (SW_RAW[SW_MOTOR]),
    .level (sw_level[SW_MOTOR]),
    .change(sw_change_unused[SW_MOTOR])
  );

  assign KEY_CLEAN_N = key_level;
  assign SW_CLEAN    = sw_level;

  // A change while the key level is still 1 is a press (1 -> 0); the pulse is
  // registered on the same edge that moves the level.
  always_ff @(posedge CLOCK_27 or posedge RESET) begin
    if (RESET) begin
      KEY_PRESS <= 1'b0;
    end else begin
      KEY_PRESS <= key_change && key_level;
    end
  end

`ifdef GATE_INPUT_HOLD_DETECT_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;

  // A change while the key level is 0 is the release edge: clear there so
  // KEY_HOLD drops together with KEY_CLEAN_N rising.
  always_ff @(posedge CLOCK_27 or posedge RESET) begin
    if (RESET) begin
      hold_cnt <= '0;
    end else if (key_change && !key_level) begin
      hold_cnt <= '0;
    end else if (!key_level && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign KEY_HOLD = (hold_cnt == HOLD_MAX);
`else
  assign KEY_HOLD = 1'b0;
`endif

endmodule

// File: tb/tb_gate_input_conditioner.sv
// Self-checking bench for gate_input_conditioner with DEBOUNCE_CYCLES=8 and
// HOLD_CYCLES=32. A behavioural model tracks, per channel, how long the
// two-cycle-delayed raw value has disagreed with the debounced level.
module tb_gate_input_conditioner;

  localparam int D = 8;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_raw_n;
  logic [1:0] sw_raw;
  logic       key_clean_n;
  logic       key_press;
  logic [1:0] sw_clean;
  logic       key_hold;

  int total = 0;
  int bad   = 0;

  gate_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .CLOCK_27   (clk),
    .RESET      (rst),
    .KEY_RAW_N  (key_raw_n),
    .SW_RAW     (sw_raw),
    .KEY_CLEAN_N(key_clean_n),
    .KEY_PRESS  (key_press),
    .SW_CLEAN   (sw_clean),
    .KEY_HOLD   (key_hold)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Vector layout: bit0 = key (idle 1), bit1 = sw sensor, bit2 = sw motor.
  logic [2:0] hist[$];
  logic [2:0] m_level;
  int         m_run[3];
  logic       m_press;
  int         m_hold;

  task automatic model_reset();
    hist.delete();
    hist.push_back(3'b001);
    hist.push_back(3'b001);
    m_level = 3'b001;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_press = 1'b0;
    m_hold  = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] seen;
    logic       old_key;
    hist.push_back(raw);
    seen    = hist.pop_front();
    old_key = m_level[0];
    for (int i = 0; i < 3; i++) begin
      if (seen[i] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_level[i] = seen[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_press = old_key && !m_level[0];
    if (!old_key && m_level[0]) m_hold = 0;
    else if (!old_key && m_hold < H) m_hold = m_hold + 1;
  endtask

  function automatic logic exp_hold();
`ifdef GATE_INPUT_HOLD_DETECT_EN
    return (m_hold == H);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver ----------------
  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic step(input logic k, input logic [1:0] s);
    key_raw_n = k;
    sw_raw    = s;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge({s, k});
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if (key_clean_n !== 1'b1 || sw_clean !== 2'b00 || key_press !== 1'b0 || key_hold !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got clean_n=%b sw=%b press=%b hold=%b exp 1 00 0 0",
               key_clean_n, sw_clean, key_press, key_hold);
    end
    for (int n = 1; n <= 50; n++) begin
      step(1'b1, 2'b00);
      total++;
      if (key_clean_n !== 1'b1 || sw_clean !== 2'b00 || key_press !== 1'b0 || key_hold !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold cycle=%0d got clean_n=%b sw=%b press=%b hold=%b exp 1 00 0 0",
                 n, key_clean_n, sw_clean, key_press, key_hold);
      end
    end
  endtask

  task automatic test_key_press();
    int fall_at = -1;
    int pulses  = 0;
    for (int n = 1; n <= 40; n++) begin
      step(1'b0, 2'b00);
      if (key_press === 1'b1) pulses++;
      if (fall_at < 0 && key_clean_n === 1'b0) begin
        fall_at = n;
        total++;
        if (key_press !== 1'b1) begin
          bad++;
          $display("FAIL press_on_fall got=%b exp=1", key_press);
        end
      end
    end
    total++;
    if (fall_at != D + 2) begin
      bad++;
      $display("FAIL press_latency got=%0d exp=%0d", fall_at, D + 2);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL press_count got=%0d exp=1", pulses);
    end
    pulses = 0;
    for (int n = 1; n <= 15; n++) begin
      step(1'b1, 2'b00);
      if (key_press === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || key_clean_n !== 1'b1) begin
      bad++;
      $display("FAIL release_no_pulse got pulses=%0d clean_n=%b exp 0 1", pulses, key_clean_n);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int lows   = 0;
    logic pat[11];
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 11; n++) begin
      step(pat[n], 2'b00);
      if (key_press === 1'b1) pulses++;
      if (key_clean_n !== 1'b1) lows++;
    end
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 2'b00);
      if (key_press === 1'b1) pulses++;
      if (key_clean_n !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL bounce_level got low_cycles=%0d exp=0", lows);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL bounce_press got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_switches();
    int rise0 = -1;
    int rise1 = -1;
    for (int n = 1; n <= 30; n++) begin
      step(1'b1, (n == 5) ? 2'b10 : 2'b11);
      if (rise0 < 0 && sw_clean[0] === 1'b1) rise0 = n;
      if (rise1 < 0 && sw_clean[1] === 1'b1) rise1 = n;
    end
    total++;
    if (rise1 != D + 2) begin
      bad++;
      $display("FAIL sw_motor_latency got=%0d exp=%0d", rise1, D + 2);
    end
    total++;
    if (rise0 != D + 7) begin
      bad++;
      $display("FAIL sw_sensor_glitch_latency got=%0d exp=%0d", rise0, D + 7);
    end
    for (int n = 0; n < 15; n++) step(1'b1, 2'b00);
    total++;
    if (sw_clean !== 2'b00) begin
      bad++;
      $display("FAIL sw_release got=%b exp=00", sw_clean);
    end
  endtask

  task automatic test_reset_mid();
    int fall_at = -1;
    for (int n = 0; n < 7; n++) step(1'b0, 2'b00);
    total++;
    if (key_clean_n !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_reset got=%b exp=1", key_clean_n);
    end
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (key_clean_n !== 1'b1 || sw_clean !== 2'b00 || key_press !== 1'b0 || key_hold !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle got clean_n=%b sw=%b press=%b hold=%b exp 1 00 0 0",
               key_clean_n, sw_clean, key_press, key_hold);
    end
    @(negedge clk);
    step(1'b0, 2'b00);
    rst = 1'b0;
    for (int n = 1; n <= 30 && fall_at < 0; n++) begin
      step(1'b0, 2'b00);
      if (key_clean_n === 1'b0) begin
        fall_at = n;
        total++;
        if (key_press !== 1'b1) begin
          bad++;
          $display("FAIL mid_press got=%b exp=1", key_press);
        end
      end
    end
    total++;
    if (fall_at != D + 2) begin
      bad++;
      $display("FAIL mid_fall_latency got=%0d exp=%0d", fall_at, D + 2);
    end
    for (int n = 0; n < 15; n++) step(1'b1, 2'b00);
  endtask

  task automatic test_hold();
    int   fall_at = -1;
    int   hold_at = -1;
    int   hold_hi = 0;
    int   rel_at  = -1;
    logic prev_hold;
    for (int n = 1; n <= D + 2 + 60; n++) begin
      step(1'b0, 2'b00);
      if (fall_at < 0 && key_clean_n === 1'b0) fall_at = n;
      if (hold_at < 0 && key_hold === 1'b1) hold_at = n;
      if (key_hold === 1'b1) hold_hi++;
    end
`ifdef GATE_INPUT_HOLD_DETECT_EN
    total++;
    if (fall_at < 0 || hold_at - fall_at != H) begin
      bad++;
      $display("FAIL hold_latency got=%0d exp=%0d", hold_at - fall_at, H);
    end
`else
    total++;
    if (hold_hi != 0) begin
      bad++;
      $display("FAIL hold_disabled got high_cycles=%0d exp=0", hold_hi);
    end
`endif
    prev_hold = key_hold;
    for (int n = 1; n <= 20 && rel_at < 0; n++) begin
      step(1'b1, 2'b00);
      if (key_clean_n === 1'b1) begin
        rel_at = n;
        total++;
        if (key_hold !== 1'b0 || prev_hold !== exp_hold_before_release()) begin
          bad++;
          $display("FAIL hold_release got hold=%b before=%b exp 0 %b",
                   key_hold, prev_hold, exp_hold_before_release());
        end
      end
      prev_hold = key_hold;
    end
    total++;
    if (rel_at != D + 2) begin
      bad++;
      $display("FAIL release_latency got=%0d exp=%0d", rel_at, D + 2);
    end
  endtask

  function automatic logic exp_hold_before_release();
`ifdef GATE_INPUT_HOLD_DETECT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_random();
    int   rem[3] = '{0, 0, 0};
    logic [2:0] v = 3'b001;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          v[i]   = 1'($urandom_range(0, 1));
          rem[i] = $urandom_range(1, 14);
        end
        rem[i]--;
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        step(v[0], v[2:1]);
        rst = 1'b0;
      end else begin
        step(v[0], v[2:1]);
      end
      total++;
      if (key_clean_n !== m_level[0]) begin
        bad++;
        $display("FAIL rand_clean_n step=%0d got=%b exp=%b", n, key_clean_n, m_level[0]);
      end
      total++;
      if (sw_clean !== m_level[2:1]) begin
        bad++;
        $display("FAIL rand_sw step=%0d got=%b exp=%b", n, sw_clean, m_level[2:1]);
      end
      total++;
      if (key_press !== m_press) begin
        bad++;
        $display("FAIL rand_press step=%0d got=%b exp=%b", n, key_press, m_press);
      end
      total++;
      if (key_hold !== exp_hold()) begin
        bad++;
        $display("FAIL rand_hold step=%0d got=%b exp=%b", n, key_hold, exp_hold());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    key_raw_n = 1'b1;
    sw_raw    = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_key_press();
    test_bounce();
    test_switches();
    test_reset_mid();
    test_hold();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
